sign_stage_front: RTL and testbench

SIGN_STAGE_FRONT -- requirements
Module: sign_stage_front

---
 rtl/sign_stage_front_if.sv | 35 +++
 rtl/sign_stage_front.sv | 163 ++++++++++++++++
 tb/tb_sign_stage_front.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sign_stage_front_if.sv
// Handshake and bus bundle for sign_stage_front: operand pair plus opcode in,
// decoded sign/exponent/fraction flags out, each side with valid/ready.
interface sign_stage_front_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         InValid;
    logic         InReady;
    logic [W-1:0] OperandX;
    logic [W-1:0] OperandY;
    logic [1:0]   Opcode;
    logic         OutValid;
    logic         OutReady;
    logic         SignOperandX;
    logic         SignOperandY;
    logic         EffOperation;
    logic         ExclusiveSign;
    logic         DSign;
    logic         DZF;
    logic         CMP1;

    modport master (
        output InValid, OperandX, OperandY, Opcode, OutReady,
        input  InReady, OutValid, SignOperandX, SignOperandY, EffOperation,
               ExclusiveSign, DSign, DZF, CMP1
    );

    modport slave (
        input  InValid, OperandX, OperandY, Opcode, OutReady,
        output InReady, OutValid, SignOperandX, SignOperandY, EffOperation,
               ExclusiveSign, DSign, DZF, CMP1
    );
endinterface

// File: rtl/sign_stage_front.sv
// Two-stage sign/exponent/fraction decode front end for an FP datapath.
// Define SIGN_FRONT_SKID_EN for a skid-buffered S1 with a registered InReady.
module sign_stage_front #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic               Clk,
    input  logic               Reset,
    sign_stage_front_if.slave  bus
);
    localparam int W = 1 + EXP_W + FRAC_W;

    typedef struct packed {
        logic signX;
        logic signY;
        logic effOp;
        logic exclSign;
        logic dSign;
        logic dzf;
        logic cmp1;
    } signFlags_t;

    function automatic signFlags_t decodeFlags(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [1:0]   op
    );
        signFlags_t       f;
        logic [EXP_W:0]   expDiff;
        expDiff    = {1'b0, x[W-2:FRAC_W]} - {1'b0, y[W-2:FRAC_W]};
        f.signX    = x[W-1];
        f.signY    = y[W-1];
        case (op)
            2'b00, 2'b01: begin
                f.effOp    = x[W-1] ^ y[W-1] ^ op[0];
                f.exclSign = 1'b0;
            end
            2'b10, 2'b11: begin
                f.effOp    = 1'b0;
                f.exclSign = x[W-1] ^ y[W-1];
            end
            default: begin
                f.effOp    = 1'b0;
                f.exclSign = 1'b0;
            end
        endcase
        // Inverted borrow of the widened subtraction gives Ex >= Ey.
        f.dSign = ~expDiff[EXP_W];
        f.dzf   = (x[W-2:FRAC_W] == y[W-2:FRAC_W]);
        f.cmp1  = (y[FRAC_W-1:0] > x[FRAC_W-1:0]);
        return f;
    endfunction

    logic         s1Valid;
    logic [W-1:0] s1X;
    logic [W-1:0] s1Y;
    logic [1:0]   s1Op;
    logic         s2Valid;
    signFlags_t   s2Flags;
    logic         s2Load;
    logic         inReadyInt;
    logic         inAccept;

    assign s2Load   = s1Valid & (~s2Valid | bus.OutReady);
    assign inAccept = bus.InValid & inReadyInt;

`ifdef SIGN_FRONT_SKID_EN
    logic         skValid;
    logic [W-1:0] skX;
    logic [W-1:0] skY;
    logic [1:0]   skOp;

    // Ready depends only on skid occupancy, so OutReady never reaches InReady.
    assign inReadyInt = ~Reset & ~skValid;

    // S1 main register plus skid slot; the skid always holds the younger entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1Valid <= 1'b0;
            s1X     <= {W{1'b0}};
            s1Y     <= {W{1'b0}};
            s1Op    <= 2'b00;
            skValid <= 1'b0;
            skX     <= {W{1'b0}};
            skY     <= {W{1'b0}};
            skOp    <= 2'b00;
        end else if (skValid) begin
            if (s2Load) begin
                s1Valid <= 1'b1;
                s1X     <= skX;
                s1Y     <= skY;
                s1Op    <= skOp;
                skValid <= 1'b0;
            end else begin
                s1Valid <= s1Valid;
                skValid <= skValid;
            end
        end else if (inAccept) begin
            if (~s1Valid | s2Load) begin
                s1Valid <= 1'b1;
                s1X     <= bus.OperandX;
                s1Y     <= bus.OperandY;
                s1Op    <= bus.Opcode;
            end else begin
                skValid <= 1'b1;
                skX     <= bus.OperandX;
                skY     <= bus.OperandY;
                skOp    <= bus.Opcode;
            end
        end else if (s2Load) begin
            s1Valid <= 1'b0;
        end else begin
            s1Valid <= s1Valid;
        end
    end
`else
    assign inReadyInt = ~Reset & (~s1Valid | s2Load);

    // S1 operand register: loads on accept, empties when S2 takes it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1Valid <= 1'b0;
            s1X     <= {W{1'b0}};
            s1Y     <= {W{1'b0}};
            s1Op    <= 2'b00;
        end else if (inAccept) begin
            s1Valid <= 1'b1;
            s1X     <= bus.OperandX;
            s1Y     <= bus.OperandY;
            s1Op    <= bus.Opcode;
        end else if (s2Load) begin
            s1Valid <= 1'b0;
        end else begin
            s1Valid <= s1Valid;
        end
    end
`endif

    // S2 flag register: decodes on load, holds flags after draining.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s2Valid <= 1'b0;
            s2Flags <= '{default: 1'b0};
        end else if (s2Load) begin
            s2Valid <= 1'b1;
            s2Flags <= decodeFlags(s1X, s1Y, s1Op);
        end else if (bus.OutReady) begin
            s2Valid <= 1'b0;
        end else begin
            s2Valid <= s2Valid;
        end
    end

    assign bus.InReady       = inReadyInt;
    assign bus.OutValid      = s2Valid;
    assign bus.SignOperandX  = s2Flags.signX;
    assign bus.SignOperandY  = s2Flags.signY;
    assign bus.EffOperation  = s2Flags.effOp;
    assign bus.ExclusiveSign = s2Flags.exclSign;
    assign bus.DSign         = s2Flags.dSign;
    assign bus.DZF           = s2Flags.dzf;
    assign bus.CMP1          = s2Flags.cmp1;
endmodule

// File: tb/tb_sign_stage_front.sv
// Self-checking bench for sign_stage_front: directed vectors, stall/reset
// sequences and a randomized run against a queue-based reference model.
module tb_sign_stage_front;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sign_stage_front_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();
    sign_stage_front #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  op;
        logic [6:0]  exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         outCount = 0;
    logic [6:0] sbQ[$];
    logic       prevStall = 1'b0;
    logic [6:0] prevFlags = 7'd0;

    // Flags packed as {SignX, SignY, EffOp, ExclSign, DSign, DZF, CMP1}.
    function automatic logic [6:0] refFlags(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] op);
        int sx, sy, ex, ey, fx, fy, opi, eff, excl;
        sx = x[31]; sy = y[31];
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0]; fy = y[22:0];
        opi = op;
        eff  = (opi < 2)  ? ((sx + sy + (opi % 2)) % 2) : 0;
        excl = (opi >= 2) ? ((sx + sy) % 2) : 0;
        return {sx[0], sy[0], eff[0], excl[0], ex >= ey, ex == ey, fy > fx};
    endfunction

    function automatic logic [6:0] dutFlags();
        return {bus.SignOperandX, bus.SignOperandY, bus.EffOperation, bus.ExclusiveSign,
                bus.DSign, bus.DZF, bus.CMP1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, observe settled values, book handshakes.
    task automatic cycle(input logic rst, input logic iv, input logic [31:0] x,
                         input logic [31:0] y, input logic [1:0] op, input logic ordy,
                         output logic acc);
        logic [6:0] expF;
        logic       r0;
        @(negedge Clk);
        Reset = rst;
        bus.InValid = iv; bus.OperandX = x; bus.OperandY = y; bus.Opcode = op;
        bus.OutReady = ordy;
        #1;
        if (prevStall) begin
            check("stall_valid_held", bus.OutValid, 1);
            check("stall_flags_held", dutFlags(), prevFlags);
        end
`ifdef SIGN_FRONT_SKID_EN
        r0 = bus.InReady;
        bus.OutReady = ~ordy;
        #1;
        check("skid_inready_vs_outready", bus.InReady, r0);
        bus.OutReady = ordy;
        #1;
`else
        r0 = 1'b0;
`endif
        acc = 1'b0;
        if (!rst) begin
            if (iv && bus.InReady) begin
                sbQ.push_back(refFlags(x, y, op));
                acc = 1'b1;
            end
            if (bus.OutValid && ordy) begin
                outCount++;
                if (sbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got flags 0x%0h with nothing expected at %0t",
                             dutFlags(), $time);
                end else begin
                    expF = sbQ.pop_front();
                    check("scoreboard_flags", dutFlags(), expF);
                end
            end
        end
        prevStall = !rst && bus.OutValid && !ordy;
        prevFlags = dutFlags();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        logic        acc;
        int          idx, base, accepted, cyc;
        logic [31:0] rx, ry;
        logic [31:0] sx[8];
        logic [31:0] sy[8];

        vecs[0] = '{32'h40400000, 32'hC0000000, 2'b00, 7'h36};
        vecs[1] = '{32'h3F800000, 32'hBFC00000, 2'b01, 7'h27};
        vecs[2] = '{32'hC0000000, 32'h40800000, 2'b10, 7'h48};
        vecs[3] = '{32'h80000000, 32'h7FFFFFFF, 2'b11, 7'h49};
        vecs[4] = '{32'h7F800001, 32'h00000000, 2'b01, 7'h14};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 7'h66};
        vecs[6] = '{32'h00800000, 32'h807FFFFF, 2'b10, 7'h2D};

        Reset = 1'b1;
        bus.InValid = 1'b0; bus.OperandX = 32'd0; bus.OperandY = 32'd0;
        bus.Opcode = 2'b00; bus.OutReady = 1'b0;

        // Reset state
        cycle(1'b1, 1'b1, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        cycle(1'b1, 1'b1, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        check("inready_in_reset", bus.InReady, 0);
        check("outvalid_in_reset", bus.OutValid, 0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        check("inready_after_reset", bus.InReady, 1);
        check("outvalid_after_reset", bus.OutValid, 0);
        check("flags_after_reset", dutFlags(), 0);

        // Directed vectors: exact 2-cycle latency and hand-derived flags
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].op, 1'b1, acc);
            check("vec_accepted", acc, 1);
            cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
            check("vec_latency_early", bus.OutValid, 0);
            cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
            check("vec_latency_valid", bus.OutValid, 1);
            check("vec_flags", dutFlags(), {25'd0, vecs[i].exp});
        end

        // Eight back-to-back transfers with OutReady low for cycles 3..6
        for (int i = 0; i < 8; i++) begin
            sx[i] = $urandom; sy[i] = $urandom;
        end
        idx = 0; base = outCount;
        for (int c = 0; c < 40 && (outCount - base) < 8; c++) begin
            cycle(1'b0, idx < 8, sx[idx % 8], sy[idx % 8], idx[1:0], !(c >= 3 && c <= 6), acc);
            if (c < 3) check("throughput_accept", acc, 1);
            if (acc) idx++;
        end
        check("stall_all_accepted", idx, 8);
        check("stall_all_emitted", outCount - base, 8);
        check("stall_queue_empty", sbQ.size(), 0);

        // Reset with two entries in flight
        cycle(1'b0, 1'b1, vecs[0].x, vecs[0].y, vecs[0].op, 1'b0, acc);
        check("inflight_a_accepted", acc, 1);
        cycle(1'b0, 1'b1, vecs[6].x, vecs[6].y, vecs[6].op, 1'b0, acc);
        check("inflight_b_accepted", acc, 1);
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, acc);
        check("midreset_inready", bus.InReady, 0);
        sbQ.delete();
        base = outCount;
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        check("postreset_outvalid", bus.OutValid, 0);
        check("postreset_flags", dutFlags(), 0);
        for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        check("stale_never_emitted", outCount - base, 0);

        // Randomized traffic against the reference model
        accepted = 0; cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            rx = $urandom; ry = $urandom;
            if ($urandom_range(0, 3) == 0) ry[30:23] = rx[30:23];
            if ($urandom_range(0, 7) == 0) ry[22:0] = rx[22:0];
            cycle(1'b0, $urandom_range(0, 9) < 7, rx, ry, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, acc);
            if (acc) accepted++;
            cyc++;
        end
        check("random_transfer_count", accepted, 10000);
        for (int c = 0; c < 20 && sbQ.size() != 0; c++)
            cycle(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b1, acc);
        check("random_drained", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
